// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: result-source select,
// load/store size codes and the access FSM states.
package mem_pkg;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_mem.sv
// Byte-enabled synchronous word RAM. The read port registers the addressed
// word every cycle; writes merge only the enabled byte lanes.
module data_mem #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[widx];
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: multi-cycle load/store on an internal RAM,
// stalling upstream and bubbling MEM/WB while an access is in flight.
module mem_stage
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY     = 2,
  parameter     INIT_FILE       = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_M,
  input  logic [1:0]  ResultSrc_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  input  logic [4:0]  rd_M,
  input  logic [31:0] PCPlus4_M,
  output logic        RegWrite_M_out,
  output logic [1:0]  ResultSrc_M_out,
  output logic [31:0] ReadData_M,
  output logic [31:0] ALUResult_M_out,
  output logic [4:0]  rd_M_out,
  output logic [31:0] PCPlus4_M_out,
  output logic        Stall_M,
  output logic        MisalignedFault_M,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  mem_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          stall, commit, we, is_load_done;
  logic          is_byte, is_half, is_word, is_signed;
  logic          access, fault;
  logic [3:0]    be;
  logic [31:0]   wdata, rdata, shifted, load_ext, ld_hold;

  always_comb begin
    is_byte   = (funct3_M == F3_B) || (funct3_M == F3_BU);
    is_half   = (funct3_M == F3_H) || (funct3_M == F3_HU);
    is_word   = !is_byte && !is_half;
    is_signed = (funct3_M == F3_B) || (funct3_M == F3_H);
    access    = (ResultSrc_M == RS_LOAD) || MemWrite_M;
    fault     = access && ((is_half && ALUResult_M[0]) ||
                           (is_word && (ALUResult_M[1:0] != 2'b00)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access && !fault) begin
          stall = 1'b1;
          if (MEM_LATENCY == 1) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = CW'(1);
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt == CW'(MEM_LATENCY - 1)) state_n = ST_DONE;
        else                             cnt_n   = cnt + CW'(1);
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // RAM write lands on the edge that enters DONE; a reset before then drops it.
  assign commit = !rst && (state != ST_DONE) && (state_n == ST_DONE);
  assign we     = commit && MemWrite_M;

  always_comb begin
    be    = 4'b1111;
    wdata = WriteData_M;
    if (is_byte) begin
      be    = 4'b0001 << ALUResult_M[1:0];
      wdata = {4{WriteData_M[7:0]}};
    end else if (is_half) begin
      be    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
      wdata = {2{WriteData_M[15:0]}};
    end
  end

  data_mem #(
    .DEPTH     (MEM_DEPTH_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_data_mem (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .widx  (ALUResult_M[AW+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    shifted  = rdata >> {ALUResult_M[1:0], 3'b000};
    load_ext = rdata;
    if (is_byte)
      load_ext = is_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
    else if (is_half)
      load_ext = is_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
  end

  // rdata was captured on the edge entering DONE; the hold register keeps it afterwards.
  assign is_load_done = (state == ST_DONE) && (ResultSrc_M == RS_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ld_hold <= '0;
    else if (is_load_done) ld_hold <= load_ext;
  end

  assign ReadData_M        = is_load_done ? load_ext : ld_hold;
  assign Stall_M           = stall && !rst;
  assign MisalignedFault_M = fault && !rst;
  assign RegWrite_M_out    = RegWrite_M && !stall && !fault && !rst;
  assign ResultSrc_M_out   = Stall_M ? RS_ALU : ResultSrc_M;
  assign rd_M_out          = Stall_M ? 5'd0 : rd_M;
  assign ALUResult_M_out   = ALUResult_M;
  assign PCPlus4_M_out     = PCPlus4_M;
  assign state_dbg         = state;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random loads/stores checked by a
// byte-array reference model through an expected-result queue.
module tb_mem_stage;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rw = 1'b0, mw = 1'b0;
  logic [1:0]  rs = 2'b00;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] alu = '0, wd = '0, pc = '0;
  logic [4:0]  rd = '0;
  logic        rw_o, stall, fault;
  logic [1:0]  rs_o, state_o;
  logic [31:0] rdata_o, alu_o, pc_o;
  logic [4:0]  rd_o;

  logic        b_rst = 1'b1;
  logic        b_rw = 1'b0, b_mw = 1'b0;
  logic [1:0]  b_rs = 2'b00;
  logic [2:0]  b_f3 = 3'b000;
  logic [31:0] b_alu = '0, b_wd = '0, b_pc = '0;
  logic [4:0]  b_rd = '0;
  logic        b_rw_o, b_stall, b_fault;
  logic [1:0]  b_rs_o, b_state_o;
  logic [31:0] b_rdata_o, b_alu_o, b_pc_o;
  logic [4:0]  b_rd_o;

  mem_stage #(.MEM_DEPTH_WORDS(1024), .MEM_LATENCY(LAT), .INIT_FILE("")) u_dut (
    .clk(clk), .rst(rst), .RegWrite_M(rw), .ResultSrc_M(rs), .MemWrite_M(mw),
    .funct3_M(f3), .ALUResult_M(alu), .WriteData_M(wd), .rd_M(rd), .PCPlus4_M(pc),
    .RegWrite_M_out(rw_o), .ResultSrc_M_out(rs_o), .ReadData_M(rdata_o),
    .ALUResult_M_out(alu_o), .rd_M_out(rd_o), .PCPlus4_M_out(pc_o),
    .Stall_M(stall), .MisalignedFault_M(fault), .state_dbg(state_o)
  );

  mem_stage #(.MEM_DEPTH_WORDS(1024), .MEM_LATENCY(1), .INIT_FILE("")) u_dut_l1 (
    .clk(clk), .rst(b_rst), .RegWrite_M(b_rw), .ResultSrc_M(b_rs), .MemWrite_M(b_mw),
    .funct3_M(b_f3), .ALUResult_M(b_alu), .WriteData_M(b_wd), .rd_M(b_rd), .PCPlus4_M(b_pc),
    .RegWrite_M_out(b_rw_o), .ResultSrc_M_out(b_rs_o), .ReadData_M(b_rdata_o),
    .ALUResult_M_out(b_alu_o), .rd_M_out(b_rd_o), .PCPlus4_M_out(b_pc_o),
    .Stall_M(b_stall), .MisalignedFault_M(b_fault), .state_dbg(b_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by 400000, required completion");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: byte-addressed RAM image, last loaded value
  logic [7:0]  ref_mem [4096];
  logic [31:0] last_ld = '0;

  function automatic logic model_misaligned(input logic [2:0] f, input logic [31:0] a);
    logic half, word;
    half = (f == 3'd1) || (f == 3'd5);
    word = !(f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5);
    return (half && a[0]) || (word && (a % 4 != 0));
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    int b;
    b = int'(a % 4096);
    case (f)
      3'd0:    return {{24{ref_mem[b][7]}}, ref_mem[b]};
      3'd4:    return {24'h0, ref_mem[b]};
      3'd1:    return {{16{ref_mem[b+1][7]}}, ref_mem[b+1], ref_mem[b]};
      3'd5:    return {16'h0, ref_mem[b+1], ref_mem[b]};
      default: return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int b, n;
    b = int'(a % 4096);
    n = (f == 3'd0 || f == 3'd4) ? 1 : ((f == 3'd1 || f == 3'd5) ? 2 : 4);
    for (int i = 0; i < n; i++) ref_mem[b+i] = d[8*i +: 8];
  endtask

  // scoreboard
  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  stalls;
  } exp_t;

  exp_t exp_q[$];
  logic inst_valid = 1'b0;
  int   stall_cnt  = 0;

  // driver
  task automatic issue(input logic rw_i, input logic [1:0] rs_i, input logic mw_i,
                       input logic [2:0] f_i, input logic [31:0] a_i,
                       input logic [31:0] d_i, input logic [4:0] rd_i);
    exp_t        e;
    logic        acc, mis;
    logic [31:0] pcv;
    int          n;
    pcv = $urandom;
    acc = (rs_i == 2'b01) || mw_i;
    mis = acc && model_misaligned(f_i, a_i);
    if (acc && !mis) begin
      if (mw_i) model_store(f_i, a_i, d_i);
      else      last_ld = model_load(f_i, a_i);
    end
    e.rw     = rw_i && !mis;
    e.rs     = rs_i;
    e.rd     = rd_i;
    e.alu    = a_i;
    e.pc     = pcv;
    e.rdata  = last_ld;
    e.fault  = mis;
    e.stalls = (acc && !mis) ? 4'(LAT) : 4'd0;
    exp_q.push_back(e);
    rw = rw_i; rs = rs_i; mw = mw_i; f3 = f_i; alu = a_i; wd = d_i; rd = rd_i; pc = pcv;
    inst_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 16);
    if (stall) check("stall_timeout", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (inst_valid && !rst) begin
      if (stall) begin
        stall_cnt++;
        check("bubble_regwrite", 32'(rw_o), 32'd0);
        check("bubble_rd", 32'(rd_o), 32'd0);
        check("bubble_resultsrc", 32'(rs_o), 32'd0);
      end else if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("regwrite_out", 32'(rw_o), 32'(e.rw));
        check("resultsrc_out", 32'(rs_o), 32'(e.rs));
        check("rd_out", 32'(rd_o), 32'(e.rd));
        check("aluresult_out", alu_o, e.alu);
        check("pcplus4_out", pc_o, e.pc);
        check("readdata", rdata_o, e.rdata);
        check("misaligned_fault", 32'(fault), 32'(e.fault));
        check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        stall_cnt = 0;
      end
    end
  end

  task automatic b_drive(input logic rw_i, input logic [1:0] rs_i, input logic mw_i,
                         input logic [2:0] f_i, input logic [31:0] a_i,
                         input logic [31:0] d_i, input logic [4:0] rd_i);
    b_rw = rw_i; b_rs = rs_i; b_mw = mw_i; b_f3 = f_i;
    b_alu = a_i; b_wd = d_i; b_rd = rd_i; b_pc = 32'h100;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sf;
    int          k;

    // reset state, with an access presented during reset
    #1;
    rw = 1'b1; rs = 2'b01; f3 = 3'b010; alu = 32'h13; rd = 5'd5;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_regwrite", 32'(rw_o), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_readdata", rdata_o, 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    rw = 1'b0; rs = 2'b00; alu = '0; rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int w = 0; w < 32; w++) issue(1'b0, 2'b00, 1'b1, 3'b010, 32'(w * 4), $urandom, 5'd0);

    issue(1'b0, 2'b00, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h10, 32'h0, 5'd3);
    check("lw_deadbeef", rdata_o, 32'hDEADBEEF);
    issue(1'b0, 2'b00, 1'b1, 3'b000, 32'h21, 32'h00000080, 5'd0);
    issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h21, 32'h0, 5'd4);
    check("lb_sign", rdata_o, 32'hFFFFFF80);
    issue(1'b1, 2'b01, 1'b0, 3'b100, 32'h21, 32'h0, 5'd4);
    check("lbu_zero", rdata_o, 32'h00000080);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h20, 32'h0, 5'd4);
    issue(1'b0, 2'b00, 1'b1, 3'b001, 32'h32, 32'h00008001, 5'd0);
    issue(1'b1, 2'b01, 1'b0, 3'b001, 32'h32, 32'h0, 5'd6);
    check("lh_sign", rdata_o, 32'hFFFF8001);
    issue(1'b1, 2'b01, 1'b0, 3'b101, 32'h32, 32'h0, 5'd6);
    check("lhu_zero", rdata_o, 32'h00008001);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h13, 32'h0, 5'd7);
    issue(1'b0, 2'b00, 1'b1, 3'b001, 32'h41, 32'h0000ABCD, 5'd0);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 5'd8);
    issue(1'b1, 2'b00, 1'b0, 3'b000, 32'h12345677, 32'h0, 5'd9);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h10, 32'h0, 5'd10);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h20, 32'h0, 5'd11);

    // random mix; addresses reach above the RAM size to exercise wrap-around
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      a = (32'($urandom_range(0, 7)) << 12) | 32'($urandom_range(0, 127));
      if (k < 3) begin
        issue(1'($urandom), (k == 0) ? 2'b10 : 2'b00, 1'b0, 3'($urandom_range(0, 7)),
              $urandom, $urandom, 5'($urandom));
      end else if (k < 6) begin
        issue(1'($urandom), 2'b01, 1'b0, 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom));
      end else begin
        sf = 3'($urandom_range(0, 5));
        if (sf >= 3'd4) sf = sf + 3'd2;
        issue(1'($urandom), 2'b00, 1'b1, sf, a, $urandom, 5'($urandom));
      end
    end

    // reset in WAIT of a store
    issue(1'b0, 2'b00, 1'b1, 3'b010, 32'h50, 32'h11111111, 5'd0);
    issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h21, 32'h0, 5'd2);
    inst_valid = 1'b0;
    rw = 1'b1; rs = 2'b00; mw = 1'b1; f3 = 3'b010; alu = 32'h50; wd = 32'h22222222; rd = 5'd1;
    @(negedge clk);
    check("wait_stall_0", 32'(stall), 32'd1);
    @(negedge clk);
    check("wait_stall_1", 32'(stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_regwrite", 32'(rw_o), 32'd0);
    check("midrst_fault", 32'(fault), 32'd0);
    check("midrst_readdata", rdata_o, 32'd0);
    last_ld = '0;
    rw = 1'b0; mw = 1'b0; rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h50, 32'h0, 5'd12);
    check("after_rst_lw", rdata_o, 32'h11111111);

    // latency-1 instance: same reset scenario
    b_rst = 1'b0;
    b_drive(1'b0, 2'b00, 1'b1, 3'b010, 32'h50, 32'h11111111, 5'd0);
    @(negedge clk);
    check("l1_sw_stall", 32'(b_stall), 32'd1);
    @(negedge clk);
    check("l1_sw_done", 32'(b_stall), 32'd0);
    @(posedge clk); #1;
    b_drive(1'b1, 2'b00, 1'b1, 3'b010, 32'h50, 32'h22222222, 5'd1);
    @(negedge clk);
    check("l1_sw2_stall", 32'(b_stall), 32'd1);
    #1 b_rst = 1'b1;
    #1;
    check("l1_midrst_stall", 32'(b_stall), 32'd0);
    check("l1_midrst_state", 32'(b_state_o), 32'd0);
    check("l1_midrst_regwrite", 32'(b_rw_o), 32'd0);
    b_drive(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    b_drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h50, 32'h0, 5'd7);
    @(negedge clk);
    check("l1_lw_stall", 32'(b_stall), 32'd1);
    check("l1_lw_bubble_rd", 32'(b_rd_o), 32'd0);
    @(negedge clk);
    check("l1_lw_done", 32'(b_stall), 32'd0);
    check("l1_lw_regwrite", 32'(b_rw_o), 32'd1);
    check("l1_lw_data", b_rdata_o, 32'h11111111);
    @(posedge clk); #1;
    b_drive(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);

    // final report
    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
